// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory bus master and its lane aligner.
package mem_pkg;

  localparam int unsigned BUS_W = 32;

  typedef enum logic [2:0] {
    OpLb  = 3'd0,
    OpLbu = 3'd1,
    OpLh  = 3'd2,
    OpLhu = 3'd3,
    OpLw  = 3'd4,
    OpSb  = 3'd5,
    OpSh  = 3'd6,
    OpSw  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StRdata = 2'd2,
    StDone  = 2'd3
  } mem_state_t;

  function automatic logic is_store(mem_op_t op);
    logic store;
    unique case (op)
      OpSb, OpSh, OpSw: store = 1'b1;
      default:          store = 1'b0;
    endcase
    return store;
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Avalon-style word bus between the data-memory master and the RAM slave.
interface mem_bus_master_if;
  import mem_pkg::*;

  logic [BUS_W-1:0] address;
  logic [3:0]       byteenable;
  logic             read;
  logic             write;
  logic [BUS_W-1:0] writedata;
  logic             waitrequest;
  logic [BUS_W-1:0] readdata;

  modport master (
    output address,
    output byteenable,
    output read,
    output write,
    output writedata,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  byteenable,
    input  read,
    input  write,
    input  writedata,
    output waitrequest,
    output readdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: enables, store replication, load extraction and
// alignment checking for one load/store op.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_t          op,
  input  logic [1:0]       addr,
  input  logic [BUS_W-1:0] wdata,
  input  logic [BUS_W-1:0] readdata,
  output logic [3:0]       byteenable,
  output logic [BUS_W-1:0] writedata,
  output logic [BUS_W-1:0] load_data,
  output logic             misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = readdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? readdata[31:16] : readdata[15:0];
  end

  always_comb begin
    byteenable = 4'b0000;
    writedata  = wdata;
    load_data  = '0;
    misaligned = 1'b0;
    unique case (op)
      OpLb: begin
        byteenable = 4'b0001 << addr;
        load_data  = {{24{byte_sel[7]}}, byte_sel};
      end
      OpLbu: begin
        byteenable = 4'b0001 << addr;
        load_data  = {24'h0, byte_sel};
      end
      OpLh: begin
        byteenable = addr[1] ? 4'b1100 : 4'b0011;
        load_data  = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      OpLhu: begin
        byteenable = addr[1] ? 4'b1100 : 4'b0011;
        load_data  = {16'h0, half_sel};
        misaligned = addr[0];
      end
      OpLw: begin
        byteenable = 4'b1111;
        load_data  = readdata;
        misaligned = |addr;
      end
      OpSb: begin
        byteenable = 4'b0001 << addr;
        writedata  = {4{wdata[7:0]}};
      end
      OpSh: begin
        byteenable = addr[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      OpSw: begin
        byteenable = 4'b1111;
        misaligned = |addr;
      end
      default: begin
        byteenable = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// Data-memory bus initiator: runs one load/store at a time as a single word transfer
// with waitrequest stalls and a one-cycle read latency.
module mem_bus_master
  import mem_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mem_op_t          op,
  input  logic [BUS_W-1:0] addr,
  input  logic [BUS_W-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [BUS_W-1:0] rdata,
  mem_bus_master_if.master bus
);

  if (READ_LATENCY != 1) begin : g_bad_read_latency
    $error("mem_bus_master: only READ_LATENCY == 1 is supported");
  end

  mem_state_t       state_q;
  mem_op_t          op_q;
  logic [1:0]       addr_lo_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [BUS_W-1:0] rdata_q;
  logic [BUS_W-1:0] address_q;
  logic [3:0]       byteenable_q;
  logic             read_q;
  logic             write_q;
  logic [BUS_W-1:0] writedata_q;

  mem_op_t          align_op;
  logic [1:0]       align_addr;
  logic [3:0]       align_be;
  logic [BUS_W-1:0] align_wdata;
  logic [BUS_W-1:0] align_load;
  logic             align_misaligned;

  // In IDLE the aligner sees the incoming request; afterwards the captured one.
  always_comb begin
    align_op   = (state_q == StIdle) ? op         : op_q;
    align_addr = (state_q == StIdle) ? addr[1:0]  : addr_lo_q;
  end

  mem_lane_align u_lane_align (
    .op         (align_op),
    .addr       (align_addr),
    .wdata      (wdata),
    .readdata   (bus.readdata),
    .byteenable (align_be),
    .writedata  (align_wdata),
    .load_data  (align_load),
    .misaligned (align_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= OpLb;
      addr_lo_q    <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      address_q    <= '0;
      byteenable_q <= 4'b0000;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q      <= op;
            addr_lo_q <= addr[1:0];
            busy_q    <= 1'b1;
            rdata_q   <= '0;
            if (align_misaligned) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q      <= StReq;
              address_q    <= {addr[BUS_W-1:2], 2'b00};
              byteenable_q <= align_be;
              writedata_q  <= is_store(op) ? align_wdata : '0;
              read_q       <= ~is_store(op);
              write_q      <= is_store(op);
            end
          end
        end
        StReq: begin
          if (!bus.waitrequest) begin
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            byteenable_q <= 4'b0000;
            writedata_q  <= '0;
            if (is_store(op_q)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRdata;
            end
          end
        end
        StRdata: begin
          rdata_q <= align_load;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    busy           = busy_q;
    done           = done_q;
    err            = err_q;
    rdata          = rdata_q;
    bus.address    = address_q;
    bus.byteenable = byteenable_q;
    bus.read       = read_q;
    bus.write      = write_q;
    bus.writedata  = writedata_q;
  end

endmodule
